// File: rtl/dmd_pkg.sv
// Shared types and constants for the HUB75 DMD scan controller.
package dmd_pkg;

  localparam int DMD_LINES  = 32;
  localparam int DMD_PIXELS = 128;
  localparam int DMD_PLANES = 4;

  typedef logic [$clog2(DMD_PLANES)-1:0] plane_t;

  typedef enum logic [2:0] {
    FETCH_TOP,
    FETCH_BOT,
    SHIFT,
    WAIT_ON,
    BLANK_PRE,
    LATCH,
    BLANK_POST
  } scan_state_t;

  // BCM weight: plane p stays lit for base << p clocks.
  function automatic int unsigned plane_on_time(input int unsigned base, input plane_t p);
    return base << p;
  endfunction

endpackage

// File: rtl/dmd_hub75_shifter.sv
// Dual-half HUB75 row shifter: two row registers shifted out LSB first under a divided panel clock.
module dmd_hub75_shifter #(
  parameter int PIXELS = 128,
  parameter int CLKDIV = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_top,
  input  logic              load_bot,
  input  logic              start,
  input  logic [PIXELS-1:0] data,
  output logic              done,
  output logic              sclk,
  output logic              pix_top,
  output logic              pix_bot
);

  localparam int DW = $clog2(CLKDIV + 1);
  localparam int BW = $clog2(PIXELS);

  logic [PIXELS-1:0] sr_top;
  logic [PIXELS-1:0] sr_bot;
  logic              active;
  logic              phase;
  logic [DW-1:0]     div_cnt;
  logic [BW-1:0]     bit_cnt;
  logic              div_last;

  assign div_last = (div_cnt == DW'(CLKDIV - 1));
  assign done     = active && phase && div_last && (bit_cnt == BW'(PIXELS - 1));
  assign sclk     = active && phase;
  assign pix_top  = active && sr_top[0];
  assign pix_bot  = active && sr_bot[0];

  // Each bit: CLKDIV clocks with sclk low (data settles), CLKDIV clocks high; shift on leaving high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_top  <= '0;
      sr_bot  <= '0;
      active  <= 1'b0;
      phase   <= 1'b0;
      div_cnt <= '0;
      bit_cnt <= '0;
    end else begin
      if (load_top) sr_top <= data;
      if (load_bot) sr_bot <= data;
      if (start) begin
        active  <= 1'b1;
        phase   <= 1'b0;
        div_cnt <= '0;
        bit_cnt <= '0;
      end else if (active) begin
        if (div_last) begin
          div_cnt <= '0;
          phase   <= ~phase;
          if (phase) begin
            sr_top <= sr_top >> 1;
            sr_bot <= sr_bot >> 1;
            if (bit_cnt == BW'(PIXELS - 1)) active <= 1'b0;
            else bit_cnt <= bit_cnt + 1'b1;
          end
        end else begin
          div_cnt <= div_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/dmd_hub75_scanctl.sv
// HUB75 scan/refresh controller for a 32-line mono DMD with BCM bit-planes.
// Optional global dimming input enabled by defining DMD_SCAN_DIM_EN.
//
//  state      | meaning
//  FETCH_TOP  | request line of top half, load top shift register
//  FETCH_BOT  | request line+LINES, load bottom shift register, start shift
//  SHIFT      | shifter running (overlaps display of the previous row)
//  WAIT_ON    | wait for the displayed row's on-time to expire
//  BLANK_PRE  | OE high before latch
//  LATCH      | lat pulse, panel address update
//  BLANK_POST | OE high after latch, then start on-time and advance plane/line
module dmd_hub75_scanctl
  import dmd_pkg::*;
#(
  parameter int PIXELS = DMD_PIXELS,
  parameter int LINES  = DMD_LINES / 2,
  parameter int PLANES = DMD_PLANES,
  parameter int CLKDIV = 2,
  parameter int ONTIME = 64,
  parameter int BLANK  = 4
) (
  input  logic              clk,
  input  logic              rst,
  output logic              row_req,
  output logic [4:0]        row_addr,
  output logic [1:0]        row_plane,
  input  logic              row_valid,
  input  logic [PIXELS-1:0] row_data,
`ifdef DMD_SCAN_DIM_EN
  input  logic [7:0]        dim,
`endif
  output logic              frame_start,
  output logic              hub75_r0,
  output logic              hub75_g0,
  output logic              hub75_b0,
  output logic              hub75_r1,
  output logic              hub75_g1,
  output logic              hub75_b1,
  output logic              hub75_a,
  output logic              hub75_b,
  output logic              hub75_c,
  output logic              hub75_d,
  output logic              hub75_clk,
  output logic              hub75_lat,
  output logic              hub75_oe
);

  localparam int LW = $clog2(LINES);
  localparam int OW = $clog2((ONTIME << (PLANES - 1)) + 1);
  localparam int TW = $clog2(BLANK + 1);

  scan_state_t   state, state_nxt;
  logic [LW-1:0] line;
  plane_t        plane;
  logic [LW-1:0] disp_line;
  logic          req_q;
  logic          row_take;
  logic [TW-1:0] tmr;
  logic [OW-1:0] on_cnt;
  logic [OW-1:0] on_thr;
  logic [OW-1:0] on_len;
  logic [OW-1:0] on_thr_nxt;
  logic          load_top;
  logic          load_bot;
  logic          shift_start;
  logic          shift_done;
  logic          pix_top;
  logic          pix_bot;
  logic          period_start;

  assign row_take     = req_q && row_valid;
  assign period_start = (state == BLANK_POST) && (tmr == '0);
  assign on_len       = OW'(plane_on_time(ONTIME, plane));

`ifdef DMD_SCAN_DIM_EN
  // OE stays low while on_cnt > on_thr, i.e. for the first (len*dim)>>8 clocks of the period.
  assign on_thr_nxt = on_len - OW'(({8'd0, on_len} * {{OW{1'b0}}, dim}) >> 8);
`else
  assign on_thr_nxt = '0;
`endif

  assign row_req     = req_q;
  assign row_addr    = 5'(line) + ((state == FETCH_BOT) ? 5'(LINES) : 5'd0);
  assign row_plane   = plane;
  assign hub75_lat   = (state == LATCH);
  assign frame_start = (state == LATCH) && (line == '0) && (plane == '0);
  assign hub75_oe    = ~(on_cnt > on_thr);
  assign hub75_r0    = pix_top;
  assign hub75_g0    = pix_top;
  assign hub75_b0    = pix_top;
  assign hub75_r1    = pix_bot;
  assign hub75_g1    = pix_bot;
  assign hub75_b1    = pix_bot;
  assign hub75_a     = disp_line[0];
  assign hub75_b     = disp_line[1];
  assign hub75_c     = disp_line[2];
  assign hub75_d     = disp_line[3];

  dmd_hub75_shifter #(
    .PIXELS (PIXELS),
    .CLKDIV (CLKDIV)
  ) u_shifter (
    .clk      (clk),
    .rst      (rst),
    .load_top (load_top),
    .load_bot (load_bot),
    .start    (shift_start),
    .data     (row_data),
    .done     (shift_done),
    .sclk     (hub75_clk),
    .pix_top  (pix_top),
    .pix_bot  (pix_bot)
  );

  always_comb begin
    state_nxt   = state;
    load_top    = 1'b0;
    load_bot    = 1'b0;
    shift_start = 1'b0;
    case (state)
      FETCH_TOP: begin
        if (row_take) begin
          load_top  = 1'b1;
          state_nxt = FETCH_BOT;
        end
      end
      FETCH_BOT: begin
        if (row_take) begin
          load_bot    = 1'b1;
          shift_start = 1'b1;
          state_nxt   = SHIFT;
        end
      end
      SHIFT:      if (shift_done) state_nxt = WAIT_ON;
      WAIT_ON:    if (on_cnt == '0) state_nxt = BLANK_PRE;
      BLANK_PRE:  if (tmr == '0) state_nxt = LATCH;
      LATCH:      state_nxt = BLANK_POST;
      BLANK_POST: if (tmr == '0) state_nxt = FETCH_TOP;
      default:    state_nxt = FETCH_TOP;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FETCH_TOP;
    else     state <= state_nxt;
  end

  // A fresh request is raised one cycle after entering a fetch state, so req visibly drops between fetches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q <= 1'b0;
    end else if (row_take) begin
      req_q <= 1'b0;
    end else if (state == FETCH_TOP || state == FETCH_BOT) begin
      req_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmr <= '0;
    end else if ((state_nxt != state) && (state_nxt == BLANK_PRE || state_nxt == BLANK_POST)) begin
      tmr <= TW'(BLANK - 1);
    end else if (tmr != '0) begin
      tmr <= tmr - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line      <= '0;
      plane     <= '0;
      disp_line <= '0;
    end else begin
      if (state == LATCH) disp_line <= line;
      if (period_start) begin
        if (plane == plane_t'(PLANES - 1)) begin
          plane <= '0;
          line  <= (line == LW'(LINES - 1)) ? '0 : line + 1'b1;
        end else begin
          plane <= plane + 1'b1;
        end
      end
    end
  end

  // On-time runs on its own so a slow fetch never stretches or cuts the lit period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      on_cnt <= '0;
      on_thr <= '0;
    end else if (period_start) begin
      on_cnt <= on_len;
      on_thr <= on_thr_nxt;
    end else if (on_cnt != '0) begin
      on_cnt <= on_cnt - 1'b1;
    end
  end

endmodule

// File: tb/tb_dmd_hub75_scanctl.sv
// Self-checking bench for dmd_hub75_scanctl: random row source, scan-order/BCM reference model.
module tb_dmd_hub75_scanctl;

  localparam int PIXELS    = 128;
  localparam int LINES     = 16;
  localparam int PLANES    = 4;
  localparam int CLKDIV    = 2;
  localparam int ONTIME    = 64;
  localparam int BLANK     = 4;
  localparam int STALL_REQ = 21;
  localparam int STALL_LAT = STALL_REQ / 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         row_req;
  logic [4:0]   row_addr;
  logic [1:0]   row_plane;
  logic         row_valid = 1'b0;
  logic [127:0] row_data = '0;
  logic         frame_start;
  logic         r0, g0, b0, r1, g1, b1;
  logic         ha, hb, hc, hd;
  logic         hclk, hlat, hoe;
`ifdef DMD_SCAN_DIM_EN
  logic [7:0]   dim = 8'd255;
`endif

  always #10 clk = ~clk;

  dmd_hub75_scanctl dut (
    .clk         (clk),
    .rst         (rst),
    .row_req     (row_req),
    .row_addr    (row_addr),
    .row_plane   (row_plane),
    .row_valid   (row_valid),
    .row_data    (row_data),
`ifdef DMD_SCAN_DIM_EN
    .dim         (dim),
`endif
    .frame_start (frame_start),
    .hub75_r0    (r0),
    .hub75_g0    (g0),
    .hub75_b0    (b0),
    .hub75_r1    (r1),
    .hub75_g1    (g1),
    .hub75_b1    (b1),
    .hub75_a     (ha),
    .hub75_b     (hb),
    .hub75_c     (hc),
    .hub75_d     (hd),
    .hub75_clk   (hclk),
    .hub75_lat   (hlat),
    .hub75_oe    (hoe)
  );

  int passed = 0;
  int total  = 0;
  int req_idx = 0;
  int lat_idx = 0;
  int fs_count = 0;
  int oe_low_total = 0;
  bit stall_armed = 1'b0;
  int lat_oe_run [0:127];
  int oe_w [0:3];
  logic [127:0] q_data [$];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Scan order: two fetches per displayed row, plane inner, line outer.
  function automatic int exp_plane(input int r);
    return (r / 2) % PLANES;
  endfunction

  function automatic int exp_addr(input int r);
    return ((r / 2) / PLANES) % LINES + (r % 2) * LINES;
  endfunction

  function automatic int exp_on(input int p);
`ifdef DMD_SCAN_DIM_EN
    return ((ONTIME << p) * int'(dim)) >> 8;
`else
    return ONTIME << p;
`endif
  endfunction

  // Row source: random latency, random data, one long stall when armed.
  initial begin : source
    bit   waiting = 1'b0;
    bit   moved   = 1'b0;
    int   cnt     = 0;
    int   lat_n   = 0;
    logic [4:0] a0 = '0;
    logic [1:0] p0 = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        row_valid = 1'b0;
        waiting   = 1'b0;
        req_idx   = 0;
        q_data.delete();
        continue;
      end
      if (row_valid) begin
        row_valid = 1'b0;
        waiting   = 1'b0;
        check("req_drop", row_req, 0);
      end else if (row_req) begin
        if (!waiting) begin
          waiting = 1'b1;
          cnt     = 0;
          moved   = 1'b0;
          a0      = row_addr;
          p0      = row_plane;
          check("req_addr", row_addr, exp_addr(req_idx));
          check("req_plane", row_plane, exp_plane(req_idx));
          lat_n = (req_idx == 0) ? 3 : int'($urandom_range(0, 6));
          if (stall_armed && req_idx == STALL_REQ) begin
            lat_n       = 2000;
            stall_armed = 1'b0;
          end
        end else if (row_addr !== a0 || row_plane !== p0) begin
          moved = 1'b1;
        end
        if (cnt >= lat_n) begin
          row_valid = 1'b1;
          row_data  = (req_idx == 0) ? 128'h1 : {$urandom, $urandom, $urandom, $urandom};
          q_data.push_back(row_data);
          req_idx++;
          if (lat_n >= 2000) check("stall_stable", moved, 0);
        end else begin
          cnt++;
        end
      end else if (waiting) begin
        check("req_held", row_req, 1);
        waiting = 1'b0;
      end
    end
  end

  // Panel-side observer: captures shifted bits, checks each latch and each OE period.
  initial begin : display_mon
    int   pulses = 0, hi_run = 0, oe_low = 0, oe_hi = 0, since_lat = 1000, last_plane = 0, exp_line = 0;
    bit   prev_clk = 1'b0, prev_oe = 1'b1, bad_hi = 1'b0, bad_rgb = 1'b0, chk_addr = 1'b0;
    logic [127:0] top_cap = '0, bot_cap = '0, et, eb;
    forever begin
      @(negedge clk);
      if (rst) begin
        pulses = 0; hi_run = 0; oe_low = 0; oe_hi = 0; since_lat = 1000; lat_idx = 0;
        prev_clk = 1'b0; prev_oe = 1'b1; bad_hi = 1'b0; bad_rgb = 1'b0; chk_addr = 1'b0;
        top_cap = '0; bot_cap = '0;
        continue;
      end
      if (chk_addr) begin
        check("line_addr", {hd, hc, hb, ha}, exp_line);
        check("lat_width", hlat, 0);
        chk_addr = 1'b0;
      end
      if (hclk && !prev_clk) begin
        if (pulses < PIXELS) begin
          top_cap[pulses] = r0;
          bot_cap[pulses] = r1;
        end
        pulses++;
      end
      if (hclk) hi_run++;
      else if (prev_clk) begin
        if (hi_run != CLKDIV) bad_hi = 1'b1;
        hi_run = 0;
      end
      if (hclk && (g0 !== r0 || b0 !== r0 || g1 !== r1 || b1 !== r1)) bad_rgb = 1'b1;
      if (frame_start) check("fs_with_lat", hlat, 1);
      if (hlat) begin
        if (q_data.size() >= 2) begin
          et = q_data.pop_front();
          eb = q_data.pop_front();
        end else begin
          et = 'x;
          eb = 'x;
        end
        check("lat_pulses", pulses, PIXELS);
        check("lat_top", top_cap, et);
        check("lat_bot", bot_cap, eb);
        check("lat_fs", frame_start, (lat_idx % (LINES * PLANES)) == 0);
        check("lat_blank_pre", oe_hi >= BLANK, 1);
        check("lat_no_clk", hclk, 0);
        check("lat_clk_hi", bad_hi, 0);
        check("lat_rgb", bad_rgb, 0);
        if (lat_idx < 128) lat_oe_run[lat_idx] = oe_hi;
        if (frame_start) fs_count++;
        exp_line   = (lat_idx / PLANES) % LINES;
        last_plane = lat_idx % PLANES;
        chk_addr   = 1'b1;
        lat_idx++;
        since_lat = 0;
        pulses = 0; top_cap = '0; bot_cap = '0; bad_hi = 1'b0; bad_rgb = 1'b0;
      end else begin
        since_lat++;
      end
      if (!hoe) begin
        if (prev_oe) check("oe_after_lat", since_lat > BLANK, 1);
        oe_low++;
        oe_low_total++;
        oe_hi = 0;
      end else begin
        if (!prev_oe) begin
          check("oe_width", oe_low, exp_on(last_plane));
          oe_w[last_plane] = oe_low;
        end
        oe_low = 0;
        oe_hi++;
      end
      prev_oe  = hoe;
      prev_clk = hclk;
    end
  end

  task automatic wait_lat(input int n, input int budget);
    int c = 0;
    while (lat_idx < n && c < budget) begin
      @(negedge clk);
      #1;
      c++;
    end
    check("latch_timeout", lat_idx >= n, 1);
  endtask

  initial begin : main
    int c = 0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_oe", hoe, 1);
    check("rst_req", row_req, 0);
    check("rst_clk", hclk, 0);
    check("rst_lat", hlat, 0);
    check("rst_fs", frame_start, 0);
    check("rst_line", {hd, hc, hb, ha}, 0);
    check("rst_pix", {r0, g0, b0, r1, g1, b1}, 0);
    check("rst_addr", {row_addr, row_plane}, 0);

    stall_armed = 1'b1;
    fs_count    = 0;
    rst = 1'b0;
    wait_lat(LINES * PLANES + 2, 60000);
    check("frame_starts", fs_count, 2);
    check("stall_used", stall_armed, 0);
    check("stall_oe_hold", lat_oe_run[STALL_LAT] >= 1500, 1);

    while (!hclk && c < 5000) begin
      @(negedge clk);
      #1;
      c++;
    end
    check("shift_seen", hclk, 1);
    rst = 1'b1;
    #1;
    check("midrst_oe", hoe, 1);
    check("midrst_req", row_req, 0);
    check("midrst_clk", hclk, 0);
    repeat (2) @(negedge clk);
    #1;
    fs_count = 0;
    rst = 1'b0;
    wait_lat(4, 6000);
    check("restart_fs", fs_count, 1);

`ifdef DMD_SCAN_DIM_EN
    rst = 1'b1;
    dim = 8'd128;
    repeat (2) @(negedge clk);
    #1;
    oe_w[2] = -1;
    rst = 1'b0;
    wait_lat(4, 6000);
    check("dim128_p2", oe_w[2], 128);

    rst = 1'b1;
    dim = 8'd0;
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b0;
    oe_low_total = 0;
    wait_lat(5, 6000);
    check("dim0_dark", oe_low_total, 0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
